// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared types, encodings and start patterns for the LED sequencer
package led_ctrl_pkg;

   localparam int LED_N = 8;

   typedef enum logic [1:0] {
      MODE_ROT_R  = 2'd0,
      MODE_ROT_L  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_e;

   localparam logic [LED_N-1:0] LIT_START       = 8'h01;
   localparam logic [LED_N-1:0] LIT_BLINK_START = 8'hFF;

   // Last step-counter value before a step: 2**speed - 1
   function automatic logic [2:0] step_limit(input logic [1:0] speed);
      case (speed)
         2'd0:    return 3'd0;
         2'd1:    return 3'd1;
         2'd2:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [LED_N-1:0] start_lit(input mode_e m);
      return (m == MODE_BLINK) ? LIT_BLINK_START : LIT_START;
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// rtl/led_pattern_ctrl_tick_gen.sv - base-tick prescaler with run enable and synchronous clear
module tick_gen #(
   parameter int BASE_DIV = 1200000,
   parameter int DIV_W    = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic base_tick
);

   localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(BASE_DIV - 1);

   logic [DIV_W-1:0] cnt;

   assign base_tick = en && (cnt == CNT_MAX);

   // Clear wins over wrap/count so a mode change always restarts the period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (base_tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - 8-LED pattern sequencer with four modes, four speeds and pause
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int BASE_DIV = 1200000,
   parameter int DIV_W    = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_btn,
   input  logic             pause_btn,
   input  logic [1:0]       speed,
   output logic [LED_N-1:0] led,
   output logic [1:0]       mode,
   output logic             running,
   output logic             step_tick
);

   state_e           st, st_nxt;
   mode_e            mode_q, mode_inc;
   logic [LED_N-1:0] lit, lit_nxt;
   logic [2:0]       pos, pos_nxt;
   logic             dir_up, dir_nxt;
   logic [2:0]       stepcnt;
   logic             base_tick;
   logic             do_step;

   tick_gen #(
      .BASE_DIV (BASE_DIV),
      .DIV_W    (DIV_W)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (st == ST_RUN),
      .clr       (mode_btn),
      .base_tick (base_tick)
   );

   assign mode_inc = mode_e'(mode_q + 2'd1);
   // A coincident mode change discards the step
   assign do_step  = base_tick && !mode_btn && (stepcnt >= step_limit(speed));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= ST_RUN;
      end else begin
         st <= st_nxt;
      end
   end

   always_comb begin
      st_nxt = st;
      if (pause_btn) begin
         case (st)
            ST_RUN:   st_nxt = ST_PAUSE;
            ST_PAUSE: st_nxt = ST_RUN;
            default:  st_nxt = ST_RUN;
         endcase
      end
   end

   always_comb begin
      lit_nxt = lit;
      pos_nxt = pos;
      dir_nxt = dir_up;
      case (mode_q)
         MODE_ROT_R: lit_nxt = {lit[0], lit[LED_N-1:1]};
         MODE_ROT_L: lit_nxt = {lit[LED_N-2:0], lit[LED_N-1]};
         MODE_BOUNCE: begin
            if (dir_up) begin
               if (pos == 3'd7) begin
                  pos_nxt = 3'd6;
                  dir_nxt = 1'b0;
               end else begin
                  pos_nxt = pos + 3'd1;
               end
            end else begin
               if (pos == 3'd0) begin
                  pos_nxt = 3'd1;
                  dir_nxt = 1'b1;
               end else begin
                  pos_nxt = pos - 3'd1;
               end
            end
            lit_nxt          = '0;
            lit_nxt[pos_nxt] = 1'b1;
         end
         MODE_BLINK: lit_nxt = ~lit;
         default:    lit_nxt = lit;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= MODE_ROT_R;
         lit       <= LIT_START;
         pos       <= 3'd0;
         dir_up    <= 1'b1;
         stepcnt   <= 3'd0;
         step_tick <= 1'b0;
      end else begin
         step_tick <= do_step;
         if (mode_btn) begin
            mode_q  <= mode_inc;
            lit     <= start_lit(mode_inc);
            pos     <= 3'd0;
            dir_up  <= 1'b1;
            stepcnt <= 3'd0;
         end else if (base_tick) begin
            if (do_step) begin
               stepcnt <= 3'd0;
               lit     <= lit_nxt;
               pos     <= pos_nxt;
               dir_up  <= dir_nxt;
            end else begin
               stepcnt <= stepcnt + 3'd1;
            end
         end
      end
   end

   assign led     = ~lit;
   assign mode    = mode_q;
   assign running = (st == ST_RUN);

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - randomized self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

   localparam int BD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_btn;
   logic       pause_btn;
   logic [1:0] speed;
   logic [7:0] led;
   logic [1:0] mode;
   logic       running;
   logic       step_tick;

   int checks   = 0;
   int failures = 0;

   // Reference state: pattern is a function of (mode, steps since mode load)
   int m_mode, m_steps, m_cnt, m_sc;
   bit m_run, m_tick;

   wire [11:0] got = {led, mode, running, step_tick};

   always #5 clk = ~clk;

   led_pattern_ctrl #(.BASE_DIV(BD), .DIV_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_btn  (mode_btn),
      .pause_btn (pause_btn),
      .speed     (speed),
      .led       (led),
      .mode      (mode),
      .running   (running),
      .step_tick (step_tick)
   );

   function automatic void m_reset();
      m_mode = 0; m_steps = 0; m_cnt = 0; m_sc = 0; m_run = 1'b1; m_tick = 1'b0;
   endfunction

   function automatic logic [7:0] model_lit(int md, int s);
      int idx, p;
      case (md)
         0: return 8'((16'h0101 >> (s % 8)) & 16'h00FF);
         1: return 8'(1 << (s % 8));
         2: begin
            idx = s % 14;
            p = (idx <= 7) ? idx : 14 - idx;
            return 8'(1 << p);
         end
         default: return (s % 2 == 0) ? 8'hFF : 8'h00;
      endcase
   endfunction

   function automatic logic [11:0] exp_vec();
      return {~model_lit(m_mode, m_steps), 2'(m_mode), m_run, m_tick};
   endfunction

   task automatic tick(input bit mb, input bit pb, input logic [1:0] spd);
      bit base, step;
      mode_btn = mb; pause_btn = pb; speed = spd;
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         base   = m_run && (m_cnt == BD - 1);
         step   = base && !mb && (m_sc >= (1 << spd) - 1);
         m_tick = step;
         if (mb) begin
            m_mode = (m_mode + 1) % 4; m_steps = 0; m_cnt = 0; m_sc = 0;
         end else if (m_run) begin
            m_cnt = base ? 0 : m_cnt + 1;
            if (base) begin
               if (step) begin m_steps++; m_sc = 0; end
               else m_sc++;
            end
         end
         if (pb) m_run = !m_run;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode_btn = 1'b0; pause_btn = 1'b0; speed = 2'd0;
      @(posedge clk); #1;
      m_reset();
      checks++;
      if (got !== {8'hFE, 2'd0, 1'b1, 1'b0}) begin
         failures++; $display("FAIL reset_state got=%h exp=%h", got, {8'hFE, 2'd0, 1'b1, 1'b0});
      end
      rst = 1'b0;
   endtask

   task automatic test_rot_r();
      int n = 0, first = -1;
      for (int i = 0; i < 40; i++) begin
         tick(0, 0, 2'd0);
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL rot_r cyc=%0d got=%h exp=%h", i, got, exp_vec());
         end
         if (step_tick) begin n++; if (first < 0) first = i; end
      end
      checks++;
      if (n !== 10 || first !== 3) begin
         failures++; $display("FAIL rot_r_rate steps=%0d first=%0d exp 10/3", n, first);
      end
   endtask

   task automatic test_speed();
      int n = 0, wait_n = 0, guard = 0;
      for (int i = 0; i < 48; i++) begin
         tick(0, 0, 2'd2);
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL speed2 cyc=%0d got=%h exp=%h", i, got, exp_vec());
         end
         if (step_tick) n++;
      end
      checks++;
      if (n !== 3) begin failures++; $display("FAIL speed2_rate steps=%0d exp=3", n); end
      while (!(m_sc == 2 && m_cnt == 0) && guard < 200) begin tick(0, 0, 2'd3); guard++; end
      checks++;
      if (guard >= 200) begin failures++; $display("FAIL speed3_reach timeout exp stepcnt=2"); end
      do begin
         tick(0, 0, 2'd0); wait_n++;
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL speed_drop cyc=%0d got=%h exp=%h", wait_n, got, exp_vec());
         end
      end while (!step_tick && wait_n < 50);
      checks++;
      if (wait_n !== BD) begin failures++; $display("FAIL speed_drop_lat got=%0d exp=%0d", wait_n, BD); end
   endtask

   task automatic test_bounce();
      int pos_seq [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
      int k = 0, guard = 0;
      tick(1, 0, 2'd0);
      tick(1, 0, 2'd0);
      checks++;
      if (got !== {8'hFE, 2'd2, 1'b1, 1'b0}) begin
         failures++; $display("FAIL bounce_enter got=%h exp=%h", got, {8'hFE, 2'd2, 1'b1, 1'b0});
      end
      while (k < 16 && guard < 200) begin
         tick(0, 0, 2'd0); guard++;
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL bounce cyc=%0d got=%h exp=%h", guard, got, exp_vec());
         end
         if (step_tick) begin
            checks++;
            if (led !== ~8'(1 << pos_seq[k])) begin
               failures++; $display("FAIL bounce_pos k=%0d led=%h exp=%h", k, led, ~8'(1 << pos_seq[k]));
            end
            k++;
         end
      end
      checks++;
      if (k !== 16) begin failures++; $display("FAIL bounce_steps got=%0d exp=16", k); end
   endtask

   task automatic test_pause();
      logic [7:0] held;
      int c, s, expect_n, n = 0;
      for (int i = 0; i < 3; i++) tick(1, 0, 2'd1);
      for (int i = 0; i < 5 + int'($urandom_range(25)); i++) tick(0, 0, 2'd1);
      tick(0, 1, 2'd1);
      c = m_cnt; s = m_sc; held = led;
      for (int i = 0; i < 40; i++) begin
         tick(0, 0, 2'($urandom_range(3)));
         checks++;
         if (got !== exp_vec() || led !== held || running !== 1'b0 || step_tick !== 1'b0) begin
            failures++; $display("FAIL pause_hold cyc=%0d got=%h exp=%h held=%h", i, got, exp_vec(), held);
         end
      end
      expect_n = (BD - 1 - c) + 1 + BD * (1 - s);
      tick(0, 1, 2'd1);
      do begin
         tick(0, 0, 2'd1); n++;
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL resume cyc=%0d got=%h exp=%h", n, got, exp_vec());
         end
      end while (!step_tick && n < 50);
      checks++;
      if (n !== expect_n) begin failures++; $display("FAIL resume_lat got=%0d exp=%0d", n, expect_n); end
   endtask

   task automatic test_collision();
      int guard = 0;
      tick(1, 0, 2'd0);
      tick(1, 0, 2'd0);
      while (!(m_run && m_cnt == BD - 1) && guard < 20) begin tick(0, 0, 2'd0); guard++; end
      tick(1, 0, 2'd0);
      checks++;
      if (got !== {8'hFE, 2'd0, 1'b1, 1'b0} || guard >= 20) begin
         failures++; $display("FAIL mode_vs_tick got=%h exp=%h", got, {8'hFE, 2'd0, 1'b1, 1'b0});
      end
      for (int i = 0; i < BD; i++) begin
         tick(0, 0, 2'd0);
         checks++;
         if (got !== exp_vec() || step_tick !== (i == BD - 1)) begin
            failures++; $display("FAIL restart cyc=%0d got=%h exp=%h", i, got, exp_vec());
         end
      end
      tick(1, 1, 2'd0);
      checks++;
      if (got !== {8'hFE, 2'd1, 1'b0, 1'b0}) begin
         failures++; $display("FAIL mode_and_pause got=%h exp=%h", got, {8'hFE, 2'd1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_random();
      logic [1:0] spd = 2'd0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(49) == 0) spd = 2'($urandom_range(3));
         tick($urandom_range(39) == 0, $urandom_range(29) == 0, spd);
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      if (!m_run) tick(0, 1, 2'd0);
      for (int i = 0; i < 4 && m_mode != 3; i++) tick(1, 0, 2'd0);
      for (int i = 0; i < 10; i++) tick(0, 0, 2'd0);
      checks++;
      if (got !== exp_vec() || mode !== 2'd3) begin
         failures++; $display("FAIL blink_pre got=%h exp=%h", got, exp_vec());
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (got !== {8'hFE, 2'd0, 1'b1, 1'b0}) begin
         failures++; $display("FAIL async_reset got=%h exp=%h", got, {8'hFE, 2'd0, 1'b1, 1'b0});
      end
      tick(0, 0, 2'd0);
      rst = 1'b0;
      m_reset();
      do begin
         tick(0, 0, 2'd0); n++;
         checks++;
         if (got !== exp_vec()) begin
            failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", n, got, exp_vec());
         end
      end while (!step_tick && n < 50);
      checks++;
      if (n !== BD) begin failures++; $display("FAIL post_reset_lat got=%0d exp=%0d", n, BD); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rot_r();
      test_speed();
      test_bounce();
      test_pause();
      test_collision();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
